// File: rtl/fir_stim_gen.sv
// Stimulus source for FIR_Filter: emits a 600 kHz sample strobe and a 3-bit signed sample.
// Each run is a burst of patterned samples followed by zero samples that flush the taps.
module fir_stim_gen #(
  parameter int unsigned CLK_DIV    = 20,
  parameter int unsigned IMP_PERIOD = 64,
  parameter int unsigned BURST_LEN  = 150,
  parameter int unsigned DRAIN_LEN  = 32
) (
  input  logic       iClk_12MHz,
  input  logic       iRst,
  input  logic       iStart,
  input  logic       iStop,
  input  logic [1:0] iMode,
  input  logic [2:0] iAmp,
  output logic       oEnSample_600kHz,
  output logic [2:0] oFirIn,
  output logic       oBusy,
  output logic       oDone,
  output logic [7:0] oSampleCnt
);

  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [7:0] LastIdx  = 8'(BURST_LEN - 1);
  localparam logic [7:0] DrainLen = 8'(DRAIN_LEN);
  localparam logic [7:0] ImpMask  = 8'(IMP_PERIOD - 1);
  localparam logic [7:0] LfsrSeed = 8'hA5;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]      stateQ, stateD;
  logic [DivW-1:0] divQ, divD, divNext;
  logic [7:0]      cntQ, cntD, cntNext;
  logic [7:0]      drainQ, drainD;
  logic [7:0]      lfsrQ, lfsrD;
  logic            stopQ, stopD;
  logic [1:0]      modeQ, modeD;
  logic [2:0]      ampQ, ampD;
  logic            strobeQ, strobeD;
  logic [2:0]      firQ, firD;
  logic            boundary;

  // Fibonacci x^8+x^6+x^5+x^4+1, shifting towards the MSB.
  function automatic logic [7:0] lfsrStep(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [2:0] pattern(input logic [1:0] mode, input logic [2:0] amp,
                                         input logic [7:0] n, input logic [7:0] lfsr);
    logic [2:0] v;
    v = 3'd0;
    case (mode)
      2'd0:    v = ((n & ImpMask) == 8'd0) ? amp : 3'd0;
      2'd1:    v = ({24'd0, n} < IMP_PERIOD) ? 3'd0 : amp;
      2'd2:    v = n[2:0];
      default: v = lfsr[2:0];
    endcase
    return v;
  endfunction

  assign divNext  = (divQ == DivLast) ? '0 : divQ + 1'b1;
  assign boundary = (divQ == DivLast);
  assign cntNext  = (cntQ == 8'hFF) ? cntQ : cntQ + 8'd1;

  always_comb begin
    stateD  = stateQ;
    divD    = divQ;
    cntD    = cntQ;
    drainD  = drainQ;
    lfsrD   = lfsrQ;
    stopD   = stopQ;
    modeD   = modeQ;
    ampD    = ampQ;
    strobeD = 1'b0;
    firD    = firQ;
    case (stateQ)
      StIdle: begin
        if (iStart) begin
          stateD  = StRun;
          divD    = '0;
          cntD    = 8'd0;
          drainD  = 8'd0;
          lfsrD   = LfsrSeed;
          stopD   = 1'b0;
          modeD   = iMode;
          ampD    = iAmp;
          strobeD = 1'b1;
          firD    = pattern(iMode, iAmp, 8'd0, LfsrSeed);
        end
      end
      StRun: begin
        divD  = divNext;
        stopD = stopQ | iStop;
        if (boundary) begin
          if (stopQ || iStop || (cntQ == LastIdx)) begin
            // The strobe slot right after the last RUN sample belongs to DRAIN.
            if (DrainLen == 8'd0) begin
              stateD = StDone;
            end else begin
              stateD  = StDrain;
              strobeD = 1'b1;
              firD    = 3'd0;
              drainD  = 8'd1;
            end
          end else begin
            lfsrD   = lfsrStep(lfsrQ);
            cntD    = cntNext;
            strobeD = 1'b1;
            firD    = pattern(modeQ, ampQ, cntNext, lfsrStep(lfsrQ));
          end
        end
      end
      StDrain: begin
        divD = divNext;
        if (boundary) begin
          if (drainQ == DrainLen) begin
            stateD = StDone;
          end else begin
            strobeD = 1'b1;
            firD    = 3'd0;
            drainD  = drainQ + 8'd1;
          end
        end
      end
      default: begin
        stateD = StIdle;
        divD   = '0;
      end
    endcase
  end

  always_ff @(posedge iClk_12MHz) begin
    if (iRst) begin
      stateQ  <= StIdle;
      divQ    <= '0;
      cntQ    <= 8'd0;
      drainQ  <= 8'd0;
      lfsrQ   <= LfsrSeed;
      stopQ   <= 1'b0;
      modeQ   <= 2'd0;
      ampQ    <= 3'd0;
      strobeQ <= 1'b0;
      firQ    <= 3'd0;
    end else begin
      stateQ  <= stateD;
      divQ    <= divD;
      cntQ    <= cntD;
      drainQ  <= drainD;
      lfsrQ   <= lfsrD;
      stopQ   <= stopD;
      modeQ   <= modeD;
      ampQ    <= ampD;
      strobeQ <= strobeD;
      firQ    <= firD;
    end
  end

  assign oEnSample_600kHz = strobeQ;
  assign oFirIn           = firQ;
  assign oBusy            = (stateQ == StRun) || (stateQ == StDrain);
  assign oDone            = (stateQ == StDone);
  assign oSampleCnt       = cntQ;

endmodule

// File: tb/tb_fir_stim_gen.sv
// Directed bench for fir_stim_gen: default-parameter instance plus a short ramp instance
// (BURST_LEN=10, DRAIN_LEN=0) sharing the clock and reset.
module tb_fir_stim_gen;

  logic       clk = 1'b0;
  logic       iRst = 1'b0;
  logic       iStart = 1'b0, iStop = 1'b0;
  logic [1:0] iMode = 2'd0;
  logic [2:0] iAmp = 3'd0;
  logic       strobe, busy, done;
  logic [2:0] fir;
  logic [7:0] cnt;

  logic       rStart = 1'b0, rStop = 1'b0;
  logic [1:0] rMode = 2'd2;
  logic [2:0] rAmp = 3'd0;
  logic       rStrobe, rBusy, rDone;
  logic [2:0] rFir;
  logic [7:0] rCnt;

  int vectors = 0;
  int miscompares = 0;
  int spacingErr = 0;
  int bad = 0;
  logic [2:0] f;
  logic [7:0] c;
  logic [7:0] lfsrRef;
  logic [2:0] expV;

  always #5 clk = ~clk;

  fir_stim_gen dut (
    .iClk_12MHz(clk), .iRst(iRst), .iStart(iStart), .iStop(iStop), .iMode(iMode),
    .iAmp(iAmp), .oEnSample_600kHz(strobe), .oFirIn(fir), .oBusy(busy), .oDone(done),
    .oSampleCnt(cnt)
  );

  fir_stim_gen #(.CLK_DIV(20), .IMP_PERIOD(64), .BURST_LEN(10), .DRAIN_LEN(0)) dutR (
    .iClk_12MHz(clk), .iRst(iRst), .iStart(rStart), .iStop(rStop), .iMode(rMode),
    .iAmp(rAmp), .oEnSample_600kHz(rStrobe), .oFirIn(rFir), .oBusy(rBusy), .oDone(rDone),
    .oSampleCnt(rCnt)
  );

  function automatic logic [7:0] lfsrModel(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance exactly one sample period; optional one-cycle iStop/iStart pulses at clock i.
  task automatic nextStrobe(input int stopAt, input int startAt,
                            output logic [2:0] fo, output logic [7:0] co);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i < 20 && strobe) spacingErr++;
      iStop  = (i == stopAt);
      iStart = (i == startAt);
    end
    iStop  = 1'b0;
    iStart = 1'b0;
    if (!strobe) spacingErr++;
    fo = fir;
    co = cnt;
  endtask

  // After the final drain strobe: 19 quiet busy clocks, then one DONE cycle.
  task automatic endOfRun(input string tag);
    int q;
    q = 0;
    for (int i = 1; i <= 19; i++) begin
      tick();
      if (strobe || done || !busy) q++;
    end
    check({tag, "_tail_quiet"}, q, 0);
    tick();
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_done_busy"}, busy, 1'b0);
    tick();
    check({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    // Reset state
    iRst = 1'b1;
    tick();
    tick();
    iRst = 1'b0;
    check("rst_outputs", {strobe, fir, busy, done, cnt}, 14'd0);
    tick();
    check("rst_idle", {strobe, busy, done}, 3'd0);

    // Impulse, amplitude -1
    iMode = 2'd0; iAmp = 3'b111; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    check("imp_first_strobe", strobe, 1'b1);
    check("imp_n0", fir, 3'b111);
    check("imp_busy", busy, 1'b1);
    check("imp_cnt0", cnt, 8'd0);
    bad = 0; spacingErr = 0;
    for (int n = 1; n < 182; n++) begin
      nextStrobe(0, 0, f, c);
      expV = (n < 150 && (n % 64) == 0) ? 3'b111 : 3'b000;
      if (f !== expV) bad++;
      if (n == 64) check("imp_n64", f, 3'b111);
      if (n == 65) check("imp_n65", f, 3'b000);
      if (n == 149) check("imp_cnt149", c, 8'd149);
    end
    check("imp_values", bad, 0);
    check("imp_spacing", spacingErr, 0);
    check("imp_drain_cnt_hold", c, 8'd149);
    endOfRun("imp");

    // Step, amplitude 3
    iMode = 2'd1; iAmp = 3'b011; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    check("step_n0", {strobe, fir}, 4'b1000);
    bad = 0; spacingErr = 0;
    for (int n = 1; n < 182; n++) begin
      nextStrobe(0, 0, f, c);
      expV = (n < 64) ? 3'b000 : ((n < 150) ? 3'b011 : 3'b000);
      if (f !== expV) bad++;
      if (n == 63) check("step_n63", f, 3'b000);
      if (n == 64) check("step_n64", f, 3'b011);
      if (n == 150) check("step_drain0", f, 3'b000);
    end
    check("step_values", bad, 0);
    check("step_spacing", spacingErr, 0);
    endOfRun("step");

    // LFSR: first four samples against the polynomial model
    iMode = 2'd3; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    lfsrRef = 8'hA5;
    check("lfsr_n0", fir, lfsrRef[2:0]);
    spacingErr = 0;
    for (int n = 1; n < 4; n++) begin
      nextStrobe(0, 0, f, c);
      lfsrRef = lfsrModel(lfsrRef);
      check($sformatf("lfsr_n%0d", n), f, lfsrRef[2:0]);
      if (n == 1) check("lfsr_n1_hand", f, 3'd2);
    end
    check("lfsr_spacing", spacingErr, 0);

    // Reset mid-run; iStart during reset must lose
    repeat (5) tick();
    iRst = 1'b1;
    tick();
    check("midrst_outputs", {strobe, fir, busy, done, cnt}, 14'd0);
    iStart = 1'b1;
    tick();
    iRst = 1'b0;
    iStart = 1'b0;
    check("midrst_start_ignored", busy, 1'b0);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (strobe || busy || done) bad++;
    end
    check("midrst_quiet", bad, 0);

    // Early stop during sample 7 (ramp), iStart during DRAIN ignored
    iMode = 2'd2; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    check("stop_n0", {strobe, fir}, 4'b1000);
    spacingErr = 0;
    for (int n = 1; n < 8; n++) nextStrobe(0, 0, f, c);
    check("stop_n7_val", f, 3'd7);
    check("stop_n7_cnt", c, 8'd7);
    nextStrobe(5, 0, f, c);
    check("stop_drain_first", {f, c}, {3'd0, 8'd7});
    check("stop_drain_busy", busy, 1'b1);
    bad = 0;
    for (int d = 2; d <= 32; d++) begin
      nextStrobe(0, (d == 2) ? 3 : 0, f, c);
      if (f !== 3'd0 || c !== 8'd7) bad++;
    end
    check("stop_drain_values", bad, 0);
    check("stop_spacing", spacingErr, 0);
    endOfRun("stop");
    iMode = 2'd0; iAmp = 3'b011; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    check("restart_strobe", strobe, 1'b1);
    check("restart_cnt", cnt, 8'd0);
    check("restart_val", fir, 3'b011);
    iRst = 1'b1;
    tick();
    iRst = 1'b0;

    // Short ramp, no drain
    rStart = 1'b1;
    tick();
    rStart = 1'b0;
    check("ramp_n0", {rStrobe, rFir}, 4'b1000);
    bad = 0; spacingErr = 0;
    for (int k = 1; k < 10; k++) begin
      for (int i = 1; i <= 20; i++) begin
        tick();
        if (i < 20 && rStrobe) spacingErr++;
      end
      if (!rStrobe) spacingErr++;
      if (rFir !== 3'(k)) bad++;
      if (k == 8) check("ramp_n8_wrap", rFir, 3'd0);
      if (k == 9) check("ramp_n9", rFir, 3'd1);
    end
    check("ramp_values", bad, 0);
    check("ramp_spacing", spacingErr, 0);
    bad = 0;
    for (int i = 1; i <= 19; i++) begin
      tick();
      if (rStrobe || rDone || !rBusy) bad++;
    end
    check("ramp_tail_quiet", bad, 0);
    tick();
    check("ramp_done", {rDone, rBusy}, 2'b10);
    tick();
    check("ramp_idle", {rDone, rBusy, rStrobe}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
